// File: rtl/load_store_unit.sv
// Load/store unit: runs one req/ack data-memory access per start, with byte
// lane steering, load extension, a request timeout and an error pulse.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses trap
// to ERR with misalign=1 instead of being issued as the aligned access.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        load_we,
  output logic        err,
  output logic        misalign,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned DW = 32;
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, ERR = 2'd3} state_t;

  state_t         state;
  state_t         state_nxt;
  logic           is_store_q;
  logic [2:0]     funct3_q;
  logic [DW-1:0]  addr_q;
  logic [DW-1:0]  wdata_q;
  logic [3:0]     be_q;
  logic [CW-1:0]  cnt;
  logic           legal_c;
  logic           mis_c;
  logic [3:0]     be_c;
  logic [DW-1:0]  wdata_c;
  logic [DW-1:0]  rdata_sh;
  logic [DW-1:0]  rdata_ext;
  logic           timeout_c;
  logic           accept_c;

  assign accept_c  = (state == IDLE) && start;
  assign timeout_c = (cnt == CW'(TIMEOUT_CYCLES - 1));

  // Decode the incoming request: legality, lane enables and replicated store data
  always_comb begin
    legal_c = 1'b0;
    be_c    = 4'b1111;
    wdata_c = store_data;
    if (is_store) legal_c = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
    else          legal_c = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010) ||
                            (funct3 == 3'b100) || (funct3 == 3'b101);
    case (funct3[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{store_data[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {addr[1], 1'b0};
        wdata_c = {2{store_data[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = store_data;
      end
    endcase
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_q;

  // Misalignment only matters for legal half/word accesses
  always_comb begin
    mis_c = legal_c && (((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00)));
  end

  // Remember why the access trapped so misalign can accompany err
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           mis_q <= 1'b0;
    else if (accept_c) mis_q <= mis_c;
  end
`else
  // Misaligned accesses are issued as the aligned access
  always_comb begin
    mis_c = 1'b0;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; an ack on the timeout cycle still completes the access
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (legal_c && !mis_c) ? REQ : ERR;
      REQ: begin
        if (mem_ack)        state_nxt = DONE;
        else if (timeout_c) state_nxt = ERR;
      end
      DONE:    state_nxt = IDLE;
      ERR:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode from state; busy also covers the start cycle itself
  always_comb begin
    busy     = 1'b0;
    done     = 1'b0;
    load_we  = 1'b0;
    err      = 1'b0;
    misalign = 1'b0;
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    busy     = (state != IDLE) || start;
    mem_req  = (state == REQ);
    mem_we   = (state == REQ) && is_store_q;
    done     = (state == DONE);
    load_we  = (state == DONE) && !is_store_q;
    err      = (state == ERR);
`ifdef MISALIGN_TRAP_EN
    misalign = (state == ERR) && mis_q;
`endif
  end

  // Latch the request so the memory side stays stable while in REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'b0000;
    end else if (accept_c) begin
      is_store_q <= is_store;
      funct3_q   <= funct3;
      addr_q     <= addr;
      wdata_q    <= wdata_c;
      be_q       <= be_c;
    end
  end

  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;

  // Request-cycle counter, cleared whenever the unit leaves REQ
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                cnt <= '0;
    else if (state == REQ)  cnt <= cnt + CW'(1);
    else                    cnt <= '0;
  end

  // Align the addressed lane to bit 0 and extend it
  always_comb begin
    rdata_sh  = mem_rdata;
    rdata_ext = mem_rdata;
    case (funct3_q[1:0])
      2'b00:   rdata_sh = mem_rdata >> {addr_q[1:0], 3'b000};
      2'b01:   rdata_sh = mem_rdata >> {addr_q[1], 4'b0000};
      default: rdata_sh = mem_rdata;
    endcase
    case (funct3_q)
      3'b000:  rdata_ext = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      3'b100:  rdata_ext = {24'h000000, rdata_sh[7:0]};
      3'b001:  rdata_ext = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b101:  rdata_ext = {16'h0000, rdata_sh[15:0]};
      default: rdata_ext = rdata_sh;
    endcase
  end

  // Load result is captured on ack so it is valid during the DONE pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          load_data <= '0;
    else if ((state == REQ) && mem_ack && !is_store_q) load_data <= rdata_ext;
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed accesses plus random
// transactions checked against a byte-level reference model.
`timescale 1ns/1ps
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy, done, load_we, err, misalign;
  logic [31:0] load_data;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_ld = 32'h0;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .store_data(store_data), .busy(busy), .done(done),
    .load_data(load_data), .load_we(load_we), .err(err), .misalign(misalign),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Access size in bytes, 0 for an illegal funct3
  function automatic int acc_size(input logic st, input logic [2:0] f3);
    if (st) return (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : (f3 == 3'd2) ? 4 : 0;
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  // Byte offset of the accessed lane within the word
  function automatic int acc_off(input int sz, input logic [31:0] a);
    if (sz == 1) return int'(a[1:0]);
    if (sz == 2) return a[1] ? 2 : 0;
    return 0;
  endfunction

  function automatic logic is_mis(input int sz, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
    return ((sz == 2) && a[0]) || ((sz == 4) && (a[1:0] != 2'b00));
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_wdata(input int sz, input logic [31:0] sd);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % sz) +: 8];
    return w;
  endfunction

  function automatic logic [31:0] model_load(input int sz, input int off, input logic sgn,
                                             input logic [31:0] rd);
    logic [63:0] v;
    logic [63:0] span;
    span = 64'd1 << (8 * sz);
    v = ({32'h0, rd} >> (8 * off)) % span;
    if (sgn && (v >= (span >> 1))) v = v - span;
    return v[31:0];
  endfunction

  task automatic junk();
    start      = 1'($urandom_range(0, 1));
    is_store   = 1'($urandom);
    funct3     = 3'($urandom);
    addr       = $urandom;
    store_data = $urandom;
  endtask

  // One complete access; ack_dly is the REQ cycle index carrying mem_ack
  task automatic run_txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input int ack_dly, input logic [31:0] rd,
                         input string name);
    int sz, off;
    logic early, emis;
    logic [3:0] ebe;
    sz    = acc_size(st, f3);
    off   = acc_off(sz, a);
    emis  = (sz != 0) && is_mis(sz, a);
    early = (sz == 0) || emis;
    ebe   = (sz == 0) ? 4'h0 : 4'(((1 << sz) - 1) << off);

    start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sd;
    #1;
    n_chk++;
    if ({busy, mem_req} !== 2'b10) begin
      n_fail++;
      $display("FAIL %s start_cycle: busy/mem_req=%b required 10", name, {busy, mem_req});
    end
    tick();
    if (early) begin
      n_chk++;
      if ({err, misalign, mem_req, done, load_we} !== {1'b1, emis, 3'b000}) begin
        n_fail++;
        $display("FAIL %s early_err: err,mis,req,done,we=%b required %b", name,
                 {err, misalign, mem_req, done, load_we}, {1'b1, emis, 3'b000});
      end
      junk();
    end else begin
      for (int k = 0; k < TO; k++) begin
        n_chk++;
        if ({mem_req, mem_we, mem_addr, mem_be, busy} !== {1'b1, st, a[31:2], 2'b00, ebe, 1'b1}) begin
          n_fail++;
          $display("FAIL %s req_k%0d: req,we,addr,be=%b,%b,%h,%b required 1,%b,%h,%b", name, k,
                   mem_req, mem_we, mem_addr, mem_be, st, {a[31:2], 2'b00}, ebe);
        end
        if (st) begin
          n_chk++;
          if (mem_wdata !== model_wdata(sz, sd)) begin
            n_fail++;
            $display("FAIL %s wdata: got %h required %h", name, mem_wdata, model_wdata(sz, sd));
          end
        end
        junk();
        mem_ack   = (k == ack_dly);
        mem_rdata = (k == ack_dly) ? rd : $urandom;
        tick();
        mem_ack = 1'b0;
        if (k == ack_dly) begin
          if (!st) exp_ld = model_load(sz, off, ~f3[2], rd);
          n_chk++;
          if ({done, err, load_we, mem_req, load_data} !== {1'b1, 1'b0, ~st, 1'b0, exp_ld}) begin
            n_fail++;
            $display("FAIL %s done: done,err,we,req=%b load_data=%h required %b %h", name,
                     {done, err, load_we, mem_req}, load_data, {1'b1, 1'b0, ~st, 1'b0}, exp_ld);
          end
          break;
        end
        if (k == TO - 1) begin
          n_chk++;
          if ({err, done, load_we, mem_req, misalign} !== 5'b10000) begin
            n_fail++;
            $display("FAIL %s timeout: err,done,we,req,mis=%b required 10000", name,
                     {err, done, load_we, mem_req, misalign});
          end
        end
      end
    end
    start = 1'b0;
    tick();
    n_chk++;
    if ({busy, done, err, load_we, mem_req, load_data} !== {5'b00000, exp_ld}) begin
      n_fail++;
      $display("FAIL %s idle_after: busy,done,err,we,req=%b load_data=%h required 00000 %h", name,
               {busy, done, err, load_we, mem_req}, load_data, exp_ld);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; is_store = 1'b0; funct3 = 3'd0; addr = '0;
    store_data = '0; mem_ack = 1'b0; mem_rdata = '0;
    tick(); tick();
    n_chk++;
    if ({busy, done, load_data, load_we, err, misalign, mem_req, mem_we, mem_addr, mem_wdata, mem_be} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%b done=%b ld=%h req=%b addr=%h wdata=%h be=%b required all 0",
               busy, done, load_data, mem_req, mem_addr, mem_wdata, mem_be);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_txn(1'b1, 3'b010, 32'h40, 32'h11223344, 0, 32'h0, "sw_0x40");
    run_txn(1'b1, 3'b000, 32'h23, 32'h000000AB, 1, 32'h0, "sb_0x23");
    run_txn(1'b0, 3'b000, 32'h21, 32'h0, 0, 32'h0000F000, "lb_0x21");
    run_txn(1'b0, 3'b100, 32'h21, 32'h0, 2, 32'h0000F000, "lbu_0x21");
    run_txn(1'b0, 3'b101, 32'h22, 32'h0, 0, 32'h80010000, "lhu_0x22");
    run_txn(1'b0, 3'b001, 32'h22, 32'h0, 0, 32'h80010000, "lh_0x22");
    run_txn(1'b1, 3'b001, 32'h16, 32'hCAFE1234, 0, 32'h0, "sh_0x16");
    // The directed test-plan values must agree with the model for these cases
    n_chk++;
    if (model_load(1, 1, 1'b1, 32'h0000F000) !== 32'hFFFFFFF0 ||
        model_load(2, 2, 1'b0, 32'h80010000) !== 32'h00008001) begin
      n_fail++;
      $display("FAIL model_sanity: got %h/%h required FFFFFFF0/00008001",
               model_load(1, 1, 1'b1, 32'h0000F000), model_load(2, 2, 1'b0, 32'h80010000));
    end
  endtask

  task automatic test_illegal_and_misalign();
    run_txn(1'b0, 3'b011, 32'h100, 32'h0, 0, 32'h0, "illegal_ld_011");
    run_txn(1'b0, 3'b110, 32'h104, 32'h0, 0, 32'h0, "illegal_ld_110");
    run_txn(1'b1, 3'b100, 32'h108, 32'h0, 0, 32'h0, "illegal_st_100");
    run_txn(1'b0, 3'b010, 32'h42, 32'h0, 0, 32'h5A5A1234, "lw_0x42");
    run_txn(1'b1, 3'b001, 32'h43, 32'h0000BEEF, 0, 32'h0, "sh_0x43");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 3'b010, 32'h80, 32'h0, 1000, 32'h0, "timeout_lw");
    run_txn(1'b0, 3'b000, 32'h81, 32'h0, TO - 1, 32'h00008000, "ack_on_timeout_cycle");
  endtask

  task automatic test_reset_mid_req();
    start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h200;
    tick();
    start = 1'b0;
    tick(); tick();
    n_chk++;
    if (mem_req !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_req_pre: mem_req=%b required 1", mem_req);
    end
    rst = 1'b1;
    #1;
    exp_ld = 32'h0;
    n_chk++;
    if ({mem_req, busy, done, err, mem_addr, load_data} !== '0) begin
      n_fail++;
      $display("FAIL rst_mid_req: req=%b busy=%b addr=%h ld=%h required all 0",
               mem_req, busy, mem_addr, load_data);
    end
    tick();
    rst = 1'b0;
    tick();
    run_txn(1'b0, 3'b001, 32'h202, 32'h0, TO - 1, 32'h7FFF0000, "after_rst_ack_last");
  endtask

  task automatic test_ack_outside_req();
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_chk++;
      if ({busy, done, load_we, err, mem_req, load_data} !== {5'b00000, exp_ld}) begin
        n_fail++;
        $display("FAIL stray_ack_%0d: busy,done,we,err,req=%b ld=%h required 00000 %h", i,
                 {busy, done, load_we, err, mem_req}, load_data, exp_ld);
      end
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int r;
      int dly;
      r   = $urandom_range(0, 9);
      dly = (r < 8) ? (r % 4) : ((r == 8) ? TO - 1 : 1000);
      run_txn(1'($urandom), 3'($urandom), $urandom, $urandom, dly, $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal_and_misalign();
    test_timeout();
    test_reset_mid_req();
    test_ack_outside_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
